// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: N:1 valid/ready stream mux (fixed select or round-robin) with a registered output stage
module stream_mux_nto1 #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_chan
);
  logic             ld, xfer, found;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] rr_ptr, gidx, nxt_ptr;
  logic [WIDTH-1:0] mux_data;
  assign ld       = ~out_valid | out_ready;
  assign in_ready = grant & {N{ld & ~rst}};
  assign xfer     = |(in_valid & in_ready);
  assign nxt_ptr  = (gidx == SEL_W'(N - 1)) ? '0 : gidx + 1'b1;
  // Round-robin: the second pass overrides with the lowest valid channel at or above rr_ptr,
  // otherwise the first pass leaves the lowest valid channel overall (wrap-around).
  always_comb begin
    gidx  = '0;
    found = 1'b0;
    if (N == 1) begin
      found = 1'b1;
    end else if (MODE == 0) begin
      gidx = sel;
      for (int i = 0; i < N; i++) found = found | (sel == SEL_W'(i));
    end else begin
      for (int i = N - 1; i >= 0; i--) if (in_valid[i]) begin
        gidx  = SEL_W'(i);
        found = 1'b1;
      end
      for (int i = N - 1; i >= 0; i--) if (in_valid[i] && SEL_W'(i) >= rr_ptr) gidx = SEL_W'(i);
    end
  end
  always_comb begin
    grant    = '0;
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = found && (gidx == SEL_W'(i));
      mux_data = grant[i] ? in_data[i*WIDTH +: WIDTH] : mux_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (ld) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= mux_data;
        out_chan <= gidx;
        if (MODE == 1) rr_ptr <= nxt_ptr;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb_stream_mux_nto1: directed scoreboard bench over fixed, round-robin, N=3 and N=1 configurations
module tb_stream_mux_nto1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_in_data, b_in_data;
  logic [3:0]  a_in_valid, a_in_ready, b_in_valid, b_in_ready;
  logic [1:0]  a_sel, a_out_chan, b_sel, b_out_chan;
  logic [7:0]  a_out_data, b_out_data;
  logic        a_out_valid, a_out_ready, b_out_valid, b_out_ready;
  logic [23:0] c_in_data;
  logic [2:0]  c_in_valid, c_in_ready;
  logic [1:0]  c_sel, c_out_chan;
  logic [7:0]  c_out_data, d_in_data, d_out_data;
  logic        c_out_valid, c_out_ready;
  logic        d_in_valid, d_in_ready, d_sel, d_out_valid, d_out_ready, d_out_chan;

  stream_mux_nto1 #(.N(4), .WIDTH(8), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sel(a_sel), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_chan(a_out_chan));
  stream_mux_nto1 #(.N(4), .WIDTH(8), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sel(b_sel), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_chan(b_out_chan));
  stream_mux_nto1 #(.N(3), .WIDTH(8), .MODE(0)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sel(c_sel), .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_chan(c_out_chan));
  stream_mux_nto1 #(.N(1), .WIDTH(8), .MODE(0)) u_d (
    .clk(clk), .rst(rst), .in_data(d_in_data), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .sel(d_sel), .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_chan(d_out_chan));

  typedef struct {int chan; int data;} exp_t;
  exp_t sb[$];
  int total = 0;
  int fails = 0;
  int ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int d);
    sb.push_back('{c, d});
  endtask

  task automatic pop_chk(input string tag, input logic v, input logic [31:0] c, input logic [31:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      fails++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(v), 1);
      chk({tag, "_chan"}, c, e.chan);
      chk({tag, "_data"}, d, e.data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic rr_step(input string tag);
    int g;
    #1;
    g = rr_pick(b_in_valid, ptr);
    chk({tag, "_ready"}, 32'(b_in_ready), 1 << g);
    push(g, (g + 1) * 'h11);
    ptr = (g + 1) % 4;
    tick();
    pop_chk(tag, b_out_valid, 32'(b_out_chan), 32'(b_out_data));
  endtask

  initial begin
    a_in_data = '0; a_in_valid = 4'hf; a_sel = '0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 4'hf; b_sel = '0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b1;
    d_in_data = '0; d_in_valid = 1'b0; d_sel = 1'b0; d_out_ready = 1'b1;
    tick();
    tick();
    chk("rst_a_valid", 32'(a_out_valid), 0);
    chk("rst_a_data", 32'(a_out_data), 0);
    chk("rst_a_chan", 32'(a_out_chan), 0);
    chk("rst_a_ready", 32'(a_in_ready), 0);
    chk("rst_b_ready", 32'(b_in_ready), 0);
    chk("rst_b_ptr", 32'(u_b.rr_ptr), 0);
    rst = 1'b0;
    b_in_valid = '0;
    a_in_data = 32'h44332211;
    b_in_data = 32'h44332211;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      #1;
      chk($sformatf("fix_ready%0d", s), 32'(a_in_ready), 1 << s);
      push(s, (s + 1) * 'h11);
      tick();
      pop_chk($sformatf("fix%0d", s), a_out_valid, 32'(a_out_chan), 32'(a_out_data));
    end
    a_sel = 2'd1;
    push(1, 'h22);
    tick();
    pop_chk("bp_load", a_out_valid, 32'(a_out_chan), 32'(a_out_data));
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_sel = 2'((k + 2) % 4);
      #1;
      chk("bp_ready", 32'(a_in_ready), 0);
      tick();
      chk("bp_hold_data", 32'(a_out_data), 'h22);
      chk("bp_hold_chan", 32'(a_out_chan), 1);
      chk("bp_hold_valid", 32'(a_out_valid), 1);
    end
    a_sel = 2'd3;
    a_out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(a_in_ready), 'b1000);
    push(3, 'h44);
    tick();
    pop_chk("bp_rel", a_out_valid, 32'(a_out_chan), 32'(a_out_data));
    b_in_valid = 4'hf;
    ptr = 0;
    for (int i = 0; i < 8; i++) rr_step("rr_full");
    b_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) rr_step("rr_sparse");
    b_in_valid = 4'b0010;
    rr_step("rr_one");
    b_in_valid = '0;
    #1;
    chk("idle_ready", 32'(b_in_ready), 0);
    tick();
    chk("idle_valid", 32'(b_out_valid), 0);
    chk("idle_ptr", 32'(u_b.rr_ptr), ptr);
    b_in_valid = 4'b1010;
    rr_step("rr_from2");
    b_in_valid = 4'b1000;
    rr_step("rr_skip");
    chk("rr_ptr_wrap", 32'(u_b.rr_ptr), ptr);
    a_in_data = 32'h4433225A;
    a_sel = 2'd0;
    b_in_valid = 4'b0100;
    rr_step("rr_pre_rst");
    chk("pre_rst_a_data", 32'(a_out_data), 'h5A);
    chk("pre_rst_b_ptr", 32'(u_b.rr_ptr), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_a_ready", 32'(a_in_ready), 0);
    chk("mid_rst_b_ready", 32'(b_in_ready), 0);
    tick();
    chk("mid_rst_a_valid", 32'(a_out_valid), 0);
    chk("mid_rst_a_data", 32'(a_out_data), 0);
    chk("mid_rst_a_chan", 32'(a_out_chan), 0);
    chk("mid_rst_b_valid", 32'(b_out_valid), 0);
    chk("mid_rst_b_ptr", 32'(u_b.rr_ptr), 0);
    rst = 1'b0;
    ptr = 0;
    a_in_valid = '0;
    b_in_valid = '0;
    c_in_data = 24'h332211;
    c_in_valid = 3'b111;
    c_sel = 2'd2;
    #1;
    chk("n3_ready", 32'(c_in_ready), 'b100);
    push(2, 'h33);
    tick();
    pop_chk("n3", c_out_valid, 32'(c_out_chan), 32'(c_out_data));
    c_sel = 2'd3;
    #1;
    chk("n3_oor_ready", 32'(c_in_ready), 0);
    tick();
    chk("n3_oor_valid", 32'(c_out_valid), 0);
    chk("n3_oor_data", 32'(c_out_data), 'h33);
    d_in_data = 8'hA5;
    d_in_valid = 1'b1;
    d_sel = 1'b1;
    #1;
    chk("n1_ready", 32'(d_in_ready), 1);
    push(0, 'hA5);
    tick();
    pop_chk("n1_a", d_out_valid, 32'(d_out_chan), 32'(d_out_data));
    d_in_data = 8'h3C;
    push(0, 'h3C);
    tick();
    pop_chk("n1_b", d_out_valid, 32'(d_out_chan), 32'(d_out_data));
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/stream_mux_nto1.md
Name: stream_mux_nto1

Overview:
- Parametrised N:1 multiplexer for valid/ready data streams, with a registered output. Next generation of the team's 2:1 combinational mux.
- Two modes, chosen at elaboration:
  - fixed: a select input picks the channel.
  - round-robin: fair arbitration across channels.
- Sits between multiple producers and one consumer. One transfer per cycle; 1-cycle latency.

Parameters:
- N, 4: number of input channels, 1..16.
- WIDTH, 8: data width per channel, ≥1.
- MODE, 0: 0 = fixed select via sel; 1 = round-robin arbitration (sel ignored).
- SEL_W, max(1,$clog2(N)): width of sel and out_chan. Derived; do not override.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_data, input, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, N: per-channel valid.
- in_ready, output, N: per-channel ready (combinational).
- sel, input, SEL_W: channel select, used only when MODE=0.
- out_data, output, WIDTH: registered output data.
- out_valid, output, 1: registered output valid.
- out_ready, input, 1: consumer ready.
- out_chan, output, SEL_W: registered index of the channel that supplied out_data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer rr_ptr=0, so channel 0 has highest priority first.
  - in_ready is all-zero while rst=1.
- Output register load enable: ld = ~out_valid | out_ready. Output stage is a single register; no skid buffer. Full throughput when out_ready is held high.
- Grant (combinational, one-hot or zero, evaluated each cycle):
  - MODE=0: grant[sel]=1 if sel<N, else no grant. in_valid of other channels is ignored.
  - MODE=1: first channel with in_valid=1, searching from rr_ptr upward modulo N.
- in_ready[i] = grant[i] & ld & ~rst. At most one in_ready bit is high in any cycle.
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. On that clk edge:
  - out_data <= channel i data; out_chan <= i; out_valid <= 1.
  - MODE=1 only: rr_ptr <= (i+1) mod N.
- If ld=1 and no transfer: out_valid <= 0; out_data and out_chan hold their last values.
- If ld=0 (out_valid=1, out_ready=0): out_data, out_chan and out_valid hold. No input is accepted.
- Simultaneous drain and fill (out_valid=1, out_ready=1, new input valid): the new word loads in the same edge. out_valid stays 1 with no bubble.
- Latency: an input accepted at edge k appears on out_* right after edge k and is consumed at the first edge where out_ready=1.
- rr_ptr advances only on a transfer. An idle cycle does not rotate priority.
- Fairness: with all N channels continuously valid and out_ready=1, the grant order is 0,1,…,N-1,0,…; each channel gets exactly 1 of every N transfers.
- Wrap-around: the grant of channel N-1 sets rr_ptr to 0.
- N=1: sel and rr_ptr are ignored; channel 0 is always granted.
- A change of sel while the output is stalled does not affect the held out_data. The new sel applies to the next load.
- Reset mid-operation:
  - Any held word is dropped (out_valid=0) and rr_ptr returns to 0.
  - No input handshake completes in the reset cycle.
- No combinational path from in_data/in_valid to out_*. Combinational paths exist only from in_valid, sel, out_ready and state to in_ready.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 holding 0x5A. Required after the next edge: out_valid=0, out_data=0, out_chan=0, in_ready=4'b0000 during reset, rr_ptr=0.
- Fixed mode (N=4, WIDTH=8, MODE=0): in_data={0x44,0x33,0x22,0x11}, all valid, out_ready=1, sel stepped 0,1,2,3.
  - out_data one cycle later is 0x11,0x22,0x33,0x44 with out_chan 0..3.
  - in_ready is one-hot matching sel.
- Round-robin (MODE=1): all four channels valid for 8 cycles, out_ready=1. Required: out_chan sequence 0,1,2,3,0,1,2,3, out_valid continuously 1, no bubbles.
- Sparse round-robin: only channels 1 and 3 valid, rr_ptr=0. Required grants 1,3,1,3. Then drop channel 1 after a grant to 3: next grant is 3 (skip-over), and rr_ptr becomes 0.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 with 0x22.
  - Required: all in_ready=0; out_data/out_chan hold 0x22/1; sel changes have no effect.
  - On release, 0x22 is consumed and the next word loads in the same edge.
- Boundaries:
  - MODE=0 with N=3 and sel=3 (out of range): in_ready=0 and out_valid drops after the current word drains.
  - N=1: channel 0 is passed through with 1-cycle latency and out_chan=0.
